usb_protocol: RTL and testbench

USB host protocol FSM; sits directly downstream of the read/write FSM and upstream of the packet encoder/decoder. Accepts one OUT or IN transaction request at a time and sequences token, data and handshake packets. Retries on NAK, corruption or timeout, and reports completion (`free`), received data (`recv_ready`/`data_up`) or abort (`bad`) back upstream.

---
 rtl/usb_protocol.sv | 218 +++++++++++++++++++++
 tb/tb_usb_protocol.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_protocol.sv
// USB host protocol sequencer: issues token/data/handshake packets for one OUT or IN
// request at a time, retrying on NAK, bad CRC or response timeout until MAX_RETRY failures.
module usb_protocol #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        input_ready,
    input  logic        send_in,
    input  logic [6:0]  addr,
    input  logic [3:0]  endp,
    input  logic [63:0] data_down,
    output logic        free,
    output logic        bad,
    output logic        recv_ready,
    output logic [63:0] data_up,
    output logic        tx_valid,
    output logic [3:0]  tx_pid,
    output logic [6:0]  tx_addr,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_data,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
    input  logic        rx_crc_ok
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned FW = $clog2(MAX_RETRY + 1);

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;

    typedef enum logic [2:0] {
        StIdle,
        StToken,
        StData,
        StWaitHs,
        StWaitData,
        StSendHs
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] fail_q, fail_d;
    logic          hs_ack_q, hs_ack_d;
    logic          req_in_q, req_in_d;
    logic [6:0]    req_addr_q, req_addr_d;
    logic [3:0]    req_endp_q, req_endp_d;
    logic [63:0]   req_data_q, req_data_d;
    logic [63:0]   data_up_q, data_up_d;
    logic          bad_q, bad_d;
    logic          recv_q, recv_d;

    logic          failure;
    logic          timed_out;
    logic [FW-1:0] fail_inc;

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            fail_q     <= '0;
            hs_ack_q   <= 1'b0;
            req_in_q   <= 1'b0;
            req_addr_q <= '0;
            req_endp_q <= '0;
            req_data_q <= '0;
            data_up_q  <= '0;
            bad_q      <= 1'b0;
            recv_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            hs_ack_q   <= hs_ack_d;
            req_in_q   <= req_in_d;
            req_addr_q <= req_addr_d;
            req_endp_q <= req_endp_d;
            req_data_q <= req_data_d;
            data_up_q  <= data_up_d;
            bad_q      <= bad_d;
            recv_q     <= recv_d;
        end
    end

    assign timed_out = (timer_q == TW'(TIMEOUT));
    // Saturating so the counter can never wrap back below MAX_RETRY.
    assign fail_inc  = (fail_q == FW'(MAX_RETRY)) ? fail_q : fail_q + FW'(1);

    always_comb begin
        state_d    = state_q;
        fail_d     = fail_q;
        hs_ack_d   = hs_ack_q;
        req_in_d   = req_in_q;
        req_addr_d = req_addr_q;
        req_endp_d = req_endp_q;
        req_data_d = req_data_q;
        data_up_d  = data_up_q;
        bad_d      = 1'b0;
        recv_d     = 1'b0;
        failure    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (input_ready) begin
                    req_in_d   = send_in;
                    req_addr_d = addr;
                    req_endp_d = endp;
                    req_data_d = data_down;
                    fail_d     = '0;
                    state_d    = StToken;
                end
            end
            StToken: begin
                if (tx_done) begin
                    state_d = req_in_q ? StWaitData : StData;
                end
            end
            StData: begin
                if (tx_done) begin
                    state_d = StWaitHs;
                end
            end
            StWaitHs: begin
                if (rx_valid) begin
                    if (rx_pid == PidAck) begin
                        state_d = StIdle;
                    end else begin
                        failure = 1'b1;
                    end
                end else if (timed_out) begin
                    failure = 1'b1;
                end
            end
            StWaitData: begin
                if (rx_valid) begin
                    if (rx_pid == PidData0) begin
                        hs_ack_d = rx_crc_ok;
                        if (rx_crc_ok) begin
                            data_up_d = rx_data;
                        end
                        state_d = StSendHs;
                    end else begin
                        failure = 1'b1;
                    end
                end else if (timed_out) begin
                    failure = 1'b1;
                end
            end
            StSendHs: begin
                if (tx_done) begin
                    if (hs_ack_q) begin
                        state_d = StIdle;
                        recv_d  = 1'b1;
                    end else begin
                        failure = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (failure) begin
            fail_d = fail_inc;
            if (fail_inc == FW'(MAX_RETRY)) begin
                state_d = StIdle;
                bad_d   = 1'b1;
            end else begin
                state_d = StToken;
            end
        end
    end

    // Timer runs only while parked in a wait state; any transition clears it.
    always_comb begin
        timer_d = '0;
        if ((state_q == StWaitHs || state_q == StWaitData) && state_d == state_q) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_comb begin
        free       = (state_q == StIdle);
        bad        = bad_q;
        recv_ready = recv_q;
        data_up    = data_up_q;
        tx_valid   = 1'b0;
        tx_pid     = '0;
        tx_addr    = '0;
        tx_endp    = '0;
        tx_data    = '0;
        unique case (state_q)
            StToken: begin
                tx_valid = 1'b1;
                tx_pid   = req_in_q ? PidIn : PidOut;
                tx_addr  = req_addr_q;
                tx_endp  = req_endp_q;
            end
            StData: begin
                tx_valid = 1'b1;
                tx_pid   = PidData0;
                tx_data  = req_data_q;
            end
            StSendHs: begin
                tx_valid = 1'b1;
                tx_pid   = hs_ack_q ? PidAck : PidNak;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_protocol.sv
// Bench for usb_protocol: emulates encoder and device, runs a vector table, a reset
// sequence and random transactions against an attempt/outcome reference model.
module tb_usb_protocol;

    localparam int unsigned TMO  = 15;
    localparam int unsigned MAXR = 3;

    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_DATA0 = 4'b0011;
    localparam logic [3:0] P_ACK   = 4'b0010;
    localparam logic [3:0] P_NAK   = 4'b1010;

    // Device behaviour per attempt
    localparam logic [1:0] K_OK  = 2'd0;  // OUT: ACK, IN: DATA0 good CRC
    localparam logic [1:0] K_NAK = 2'd1;  // device answers NAK
    localparam logic [1:0] K_CRC = 2'd2;  // DATA0 with bad CRC (unexpected PID for OUT)
    localparam logic [1:0] K_TMO = 2'd3;  // no answer

    logic        clk = 1'b0;
    logic        rst_L;
    logic        input_ready, send_in;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data_down;
    logic        free, bad, recv_ready;
    logic [63:0] data_up;
    logic        tx_valid;
    logic [3:0]  tx_pid;
    logic [6:0]  tx_addr;
    logic [3:0]  tx_endp;
    logic [63:0] tx_data;
    logic        tx_done, rx_valid;
    logic [3:0]  rx_pid;
    logic [63:0] rx_data;
    logic        rx_crc_ok;

    always #5 clk = ~clk;

    usb_protocol #(
        .TIMEOUT  (TMO),
        .MAX_RETRY(MAXR)
    ) dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .input_ready(input_ready),
        .send_in    (send_in),
        .addr       (addr),
        .endp       (endp),
        .data_down  (data_down),
        .free       (free),
        .bad        (bad),
        .recv_ready (recv_ready),
        .data_up    (data_up),
        .tx_valid   (tx_valid),
        .tx_pid     (tx_pid),
        .tx_addr    (tx_addr),
        .tx_endp    (tx_endp),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .rx_valid   (rx_valid),
        .rx_pid     (rx_pid),
        .rx_data    (rx_data),
        .rx_crc_ok  (rx_crc_ok)
    );

    typedef struct {
        bit              is_in;
        logic [6:0]      a;
        logic [3:0]      e;
        logic [63:0]     d;
        logic [63:0]     rdata;
        logic [2:0][1:0] kind;
        logic [2:0][7:0] dly;
        int              exp_att;
        bit              exp_bad;
        bit              exp_recv;
        logic [63:0]     exp_up;
    } vec_t;

    int          n_total = 0;
    int          n_fail  = 0;
    logic [63:0] exp_data_up = 64'h0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_total++;
        n_fail++;
        $display("FAIL %s: got unexpected DUT state want retry token or completion", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] txv();
        return {tx_valid, tx_pid, tx_addr, tx_endp, tx_data};
    endfunction

    function automatic logic [2:0][1:0] kinds3(input logic [1:0] k0, input logic [1:0] k1,
                                               input logic [1:0] k2);
        return {k2, k1, k0};
    endfunction

    function automatic logic [2:0][7:0] dlys3(input logic [7:0] d0, input logic [7:0] d1,
                                              input logic [7:0] d2);
        return {d2, d1, d0};
    endfunction

    // Reference: the first attempt the device answers properly succeeds; otherwise abort.
    function automatic void model(input logic [2:0][1:0] kind, output int att, output bit ok);
        att = MAXR;
        ok  = 1'b0;
        for (int k = MAXR - 1; k >= 0; k--) begin
            if (kind[k] == K_OK) begin
                att = k + 1;
                ok  = 1'b1;
            end
        end
    endfunction

    // Act as the encoder: hold tx_done off for a random time, checking the packet stays put.
    task automatic send_pkt(input string nm, input logic [3:0] pid, input logic [6:0] a,
                            input logic [3:0] e, input logic [63:0] d);
        int hold;
        hold = int'($urandom_range(0, 2));
        for (int i = 0; i <= hold; i++) begin
            chk(nm, 128'(txv()), 128'({1'b1, pid, a, e, d}));
            tx_done = (i == hold);
            tick();
        end
        tx_done = 1'b0;
    endtask

    // Act as the device during the wait window; returns on the cycle the outcome shows.
    task automatic respond(input bit is_in, input logic [1:0] kind, input int dly,
                           input logic [63:0] rdata);
        bit quiet;
        int n_idle;
        quiet  = 1'b1;
        n_idle = (kind == K_TMO) ? int'(TMO) + 1 : dly;
        for (int i = 0; i < n_idle; i++) begin
            if (tx_valid || free) quiet = 1'b0;
            tick();
        end
        chk("wait_quiet", 128'(quiet), 128'(1));
        if (kind != K_TMO) begin
            rx_valid  = 1'b1;
            rx_crc_ok = (kind != K_CRC);
            rx_data   = (is_in && kind == K_OK) ? rdata : {$urandom, $urandom};
            if (kind == K_NAK)  rx_pid = P_NAK;
            else if (is_in)     rx_pid = P_DATA0;
            else if (kind == K_OK) rx_pid = P_ACK;
            else                rx_pid = P_DATA0;
            tick();
            rx_valid  = 1'b0;
            rx_pid    = 4'h0;
            rx_crc_ok = 1'b0;
            if (is_in && kind != K_NAK) begin
                if (kind == K_OK) chk("data_up_next", 128'(data_up), 128'(rdata));
                send_pkt("handshake", (kind == K_OK) ? P_ACK : P_NAK, 7'h0, 4'h0, 64'h0);
            end
        end
    endtask

    task automatic resync();
        rst_L = 1'b0;
        tick();
        rst_L = 1'b1;
        exp_data_up = 64'h0;
    endtask

    task automatic run_txn(input bit is_in, input logic [6:0] a, input logic [3:0] e,
                           input logic [63:0] d, input logic [63:0] rdata,
                           input logic [2:0][1:0] kind, input logic [2:0][7:0] dly,
                           output int att, output bit got_bad, output bit got_recv);
        bit done;
        int k;
        done     = 1'b0;
        att      = 0;
        got_bad  = 1'b0;
        got_recv = 1'b0;
        chk("idle_free", 128'(free), 128'(1));
        input_ready = 1'b1;
        send_in     = is_in;
        addr        = a;
        endp        = e;
        data_down   = d;
        tick();
        // Scramble the request lines to prove the DUT uses its latched copy.
        input_ready = 1'b0;
        send_in     = ~is_in;
        addr        = 7'($urandom);
        endp        = 4'($urandom);
        data_down   = {$urandom, $urandom};
        chk("accept_token", 128'({free, tx_valid}), 128'(2'b01));
        while (!done) begin
            k = (att < int'(MAXR)) ? att : int'(MAXR) - 1;
            att++;
            send_pkt("token", is_in ? P_IN : P_OUT, a, e, 64'h0);
            if (!is_in) send_pkt("data0", P_DATA0, 7'h0, 4'h0, d);
            respond(is_in, kind[k], int'(dly[k]), rdata);
            if (free) begin
                done     = 1'b1;
                got_bad  = bad;
                got_recv = recv_ready;
                chk("done_tx_idle", 128'(txv()), 128'(0));
                tick();
                chk("pulse_one_cycle", 128'({free, bad, recv_ready}), 128'(3'b100));
            end else if (!tx_valid) begin
                fail("after_attempt");
                done = 1'b1;
                resync();
            end else if (att >= 2 * int'(MAXR)) begin
                fail("retry_runaway");
                done = 1'b1;
                resync();
            end
        end
    endtask

    vec_t        vecs[9];
    int          att, att_e;
    bit          gb, gr, ok_e;
    bit          r_in;
    logic [2:0][1:0] r_kind;
    logic [2:0][7:0] r_dly;

    initial begin
        vecs[0] = '{1'b0, 7'd5, 4'd4, 64'h1234, 64'h0, kinds3(K_OK, K_OK, K_OK),
                    dlys3(3, 0, 0), 1, 1'b0, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 7'd5, 4'd8, 64'h0, 64'hDEADBEEF, kinds3(K_OK, K_OK, K_OK),
                    dlys3(2, 0, 0), 1, 1'b0, 1'b1, 64'hDEADBEEF};
        vecs[2] = '{1'b0, 7'h11, 4'd2, 64'hAA55, 64'h0, kinds3(K_NAK, K_NAK, K_OK),
                    dlys3(1, 4, 0), 3, 1'b0, 1'b0, 64'hDEADBEEF};
        vecs[3] = '{1'b1, 7'h7F, 4'hF, 64'h0, 64'hCAFEF00D_12345678,
                    kinds3(K_CRC, K_OK, K_OK), dlys3(0, 5, 0), 2, 1'b0, 1'b1,
                    64'hCAFEF00D_12345678};
        vecs[4] = '{1'b0, 7'h22, 4'd1, 64'h55, 64'h0, kinds3(K_TMO, K_TMO, K_TMO),
                    dlys3(0, 0, 0), 3, 1'b1, 1'b0, 64'hCAFEF00D_12345678};
        vecs[5] = '{1'b1, 7'd3, 4'd3, 64'h0, 64'h77, kinds3(K_NAK, K_TMO, K_CRC),
                    dlys3(1, 0, 7), 3, 1'b1, 1'b0, 64'hCAFEF00D_12345678};
        vecs[6] = '{1'b0, 7'd1, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                    kinds3(K_OK, K_OK, K_OK), dlys3(8'(TMO), 0, 0), 1, 1'b0, 1'b0,
                    64'hCAFEF00D_12345678};
        vecs[7] = '{1'b1, 7'd9, 4'd9, 64'h0, 64'hABC, kinds3(K_OK, K_OK, K_OK),
                    dlys3(8'(TMO), 0, 0), 1, 1'b0, 1'b1, 64'hABC};
        vecs[8] = '{1'b0, 7'h40, 4'd0, 64'h1, 64'h0, kinds3(K_CRC, K_TMO, K_NAK),
                    dlys3(2, 0, 3), 3, 1'b1, 1'b0, 64'hABC};

        rst_L = 1'b0; input_ready = 1'b0; send_in = 1'b0; addr = '0; endp = '0;
        data_down = '0; tx_done = 1'b0; rx_valid = 1'b0; rx_pid = '0; rx_data = '0;
        rx_crc_ok = 1'b0;
        tick();
        tick();
        chk("reset_ctrl", 128'({free, bad, recv_ready, tx_valid, tx_pid, tx_addr, tx_endp}),
            128'({1'b1, 18'h0}));
        chk("reset_data", 128'({data_up, tx_data}), 128'(0));
        rst_L = 1'b1;
        tick();

        // rx traffic while idle must not disturb anything
        rx_valid = 1'b1; rx_pid = P_DATA0; rx_crc_ok = 1'b1; rx_data = 64'hBAD0BAD0;
        tick();
        rx_valid = 1'b0;
        chk("rx_idle_ignored", 128'({free, tx_valid, data_up}), 128'({2'b10, 64'h0}));

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].is_in, vecs[i].a, vecs[i].e, vecs[i].d, vecs[i].rdata,
                    vecs[i].kind, vecs[i].dly, att, gb, gr);
            chk($sformatf("vec%0d_attempts", i), 128'(att), 128'(vecs[i].exp_att));
            chk($sformatf("vec%0d_bad_recv", i), 128'({gb, gr}),
                128'({vecs[i].exp_bad, vecs[i].exp_recv}));
            chk($sformatf("vec%0d_data_up", i), 128'(data_up), 128'(vecs[i].exp_up));
            tick();
        end
        exp_data_up = 64'hABC;

        // Reset while waiting for IN data, with a busy-time request that must be ignored
        input_ready = 1'b1; send_in = 1'b1; addr = 7'd5; endp = 4'd8;
        tick();
        input_ready = 1'b0;
        send_pkt("rst_token", P_IN, 7'd5, 4'd8, 64'h0);
        input_ready = 1'b1; send_in = 1'b0; addr = 7'd1;
        tick();
        tick();
        input_ready = 1'b0;
        chk("busy_ignored", 128'({free, tx_valid}), 128'(2'b00));
        rst_L = 1'b0;
        tick();
        rst_L = 1'b1;
        chk("reset_mid_wait", 128'({free, tx_valid, bad, data_up}), 128'({3'b100, 64'h0}));
        exp_data_up = 64'h0;
        tick();
        chk("reset_stays_idle", 128'({free, tx_valid, bad}), 128'(3'b100));
        run_txn(1'b0, 7'd6, 4'd2, 64'h600D, 64'h0, kinds3(K_OK, K_OK, K_OK),
                dlys3(0, 0, 0), att, gb, gr);
        chk("post_reset_txn", 128'({att[3:0], gb, gr}), 128'({4'd1, 2'b00}));

        for (int i = 0; i < 40; i++) begin
            logic [63:0] rd;
            logic [2:0][1:0] kk;
            r_in = 1'($urandom_range(0, 1));
            rd   = {$urandom, $urandom};
            for (int j = 0; j < 3; j++) begin
                kk[j]    = ($urandom_range(0, 9) < 5) ? K_OK : 2'($urandom_range(1, 3));
                r_dly[j] = 8'($urandom_range(0, TMO));
            end
            r_kind = kk;
            model(r_kind, att_e, ok_e);
            if (ok_e && r_in) exp_data_up = rd;
            run_txn(r_in, 7'($urandom), 4'($urandom), {$urandom, $urandom}, rd, r_kind, r_dly,
                    att, gb, gr);
            chk($sformatf("rnd%0d_attempts", i), 128'(att), 128'(att_e));
            chk($sformatf("rnd%0d_bad_recv", i), 128'({gb, gr}), 128'({~ok_e, ok_e & r_in}));
            chk($sformatf("rnd%0d_data_up", i), 128'(data_up), 128'(exp_data_up));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_fail);
        $finish;
    end

endmodule
